// File: rtl/branch_predictor_pkg.sv
// Shared helpers for the branch predictor: counter encodings, PC field extraction,
// and saturating arithmetic. Values travel as 64-bit words so any parameterisation fits.
package branch_predictor_pkg;

  function automatic int idx_w(int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(int xlen, int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  function automatic logic [63:0] ctr_max(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] ctr_weak_t(int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] ctr_weak_nt(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // PC bits [1:0] are ignored; the index sits just above them
  function automatic logic [63:0] idx_of(logic [63:0] pc, int iw);
    return (pc >> 2) & ((64'd1 << iw) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(logic [63:0] pc, int iw);
    return pc >> (iw + 2);
  endfunction

  function automatic logic [63:0] sat_inc(logic [63:0] v, int w);
    return (v == ctr_max(w)) ? v : v + 64'd1;
  endfunction

  function automatic logic [63:0] sat_dec(logic [63:0] v);
    return (v == 64'd0) ? v : v - 64'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> predictor bus: IF lookup, resolved-branch update, and stat readout.
interface branch_predictor_if #(
  parameter int XLEN      = 32,
  parameter int STAT_BITS = 32
);
  logic                 lk_valid;
  logic [XLEN-1:0]      lk_pc;
  logic                 lk_taken;
  logic [XLEN-1:0]      lk_next_pc;
  logic                 up_valid;
  logic [XLEN-1:0]      up_pc;
  logic                 up_is_jump;
  logic                 up_taken;
  logic [XLEN-1:0]      up_target;
  logic                 up_pred_taken;
  logic [XLEN-1:0]      up_pred_pc;
  logic                 mispredict;
  logic [XLEN-1:0]      redirect_pc;
  logic [STAT_BITS-1:0] stat_lookups;
  logic [STAT_BITS-1:0] stat_mispred;

  modport master (
    output lk_valid, lk_pc, up_valid, up_pc, up_is_jump, up_taken, up_target,
           up_pred_taken, up_pred_pc,
    input  lk_taken, lk_next_pc, mispredict, redirect_pc, stat_lookups, stat_mispred
  );

  modport slave (
    input  lk_valid, lk_pc, up_valid, up_pc, up_is_jump, up_taken, up_target,
           up_pred_taken, up_pred_pc,
    output lk_taken, lk_next_pc, mispredict, redirect_pc, stat_lookups, stat_mispred
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with load; priority is reset, set, inc, dec.
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic         set,
  input  logic [W-1:0] set_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)   q <= rst_val;
    else if (set) q <= set_val;
    else if (inc) q <= W'(sat_inc(64'(q), W));
    else if (dec) q <= W'(sat_dec(64'(q)));
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters; combinational lookup,
// combinational misprediction detection, registered table update.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(XLEN, ENTRIES);
  localparam logic [CTR_BITS-1:0] C_MAX = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] C_WT  = CTR_BITS'(ctr_weak_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] C_WNT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

  logic [ENTRIES-1:0]               valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]    tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]     tgt_q;
  logic [ENTRIES-1:0][CTR_BITS-1:0] ctr_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, up_tk;
  logic [XLEN-1:0]  correct_pc;
  logic             upd_set, upd_inc, upd_dec, wr_tgt, wr_alloc;
  logic [CTR_BITS-1:0] set_val;

  assign lk_idx = IDX_W'(idx_of(64'(bp.lk_pc), IDX_W));
  assign lk_tag = TAG_W'(tag_of(64'(bp.lk_pc), IDX_W));
  assign up_idx = IDX_W'(idx_of(64'(bp.up_pc), IDX_W));
  assign up_tag = TAG_W'(tag_of(64'(bp.up_pc), IDX_W));

  // Lookup reads the registered table only, so a same-cycle update is not visible
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign bp.lk_taken   = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign bp.lk_next_pc = bp.lk_taken ? tgt_q[lk_idx] : bp.lk_pc + XLEN'(4);

  assign up_tk          = bp.up_taken || bp.up_is_jump;
  assign correct_pc     = up_tk ? bp.up_target : bp.up_pc + XLEN'(4);
  assign bp.mispredict  = bp.up_valid && (correct_pc != bp.up_pred_pc);
  assign bp.redirect_pc = correct_pc;

  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign upd_set  = bp.up_valid && (bp.up_is_jump || (!up_hit && bp.up_taken));
  assign set_val  = bp.up_is_jump ? C_MAX : C_WT;
  assign upd_inc  = bp.up_valid && up_hit && !bp.up_is_jump && bp.up_taken;
  assign upd_dec  = bp.up_valid && up_hit && !up_tk;
  assign wr_tgt   = bp.up_valid && up_tk;
  assign wr_alloc = bp.up_valid && !up_hit && up_tk;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    logic sel;
    assign sel = (up_idx == IDX_W'(e));
    sat_counter #(.W(CTR_BITS)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (C_WNT),
      .set     (sel && upd_set),
      .set_val (set_val),
      .inc     (sel && upd_inc),
      .dec     (sel && upd_dec),
      .q       (ctr_q[e])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
    end else begin
      if (wr_tgt) tgt_q[up_idx] <= bp.up_target;
      if (wr_alloc) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
      end
    end
  end

  sat_counter #(.W(STAT_BITS)) u_stat_lk (
    .clk (clk), .rst_n (rst_n), .rst_val ('0), .set (1'b0), .set_val ('0),
    .inc (bp.lk_valid), .dec (1'b0), .q (bp.stat_lookups)
  );

  sat_counter #(.W(STAT_BITS)) u_stat_mp (
    .clk (clk), .rst_n (rst_n), .rst_val ('0), .set (1'b0), .set_val ('0),
    .inc (bp.mispredict), .dec (1'b0), .q (bp.stat_mispred)
  );

  // The carried taken bit is implied by the carried PC; only the PC is compared
  logic unused_pred_taken;
  assign unused_pred_taken = bp.up_pred_taken;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, CTR_BITS=2, STAT_BITS=4 build).
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32), .STAT_BITS(4)) bus ();

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2), .STAT_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bus)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(string tag, logic [31:0] pc, logic exp_t, logic [31:0] exp_pc);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
    #1;
    chk({tag, ".taken"}, 64'(bus.lk_taken), 64'(exp_t));
    chk({tag, ".next"},  64'(bus.lk_next_pc), 64'(exp_pc));
  endtask

  task automatic update(logic [31:0] pc, logic jmp, logic tk, logic [31:0] tgt, logic [31:0] pred);
    bus.up_valid      = 1'b1;
    bus.up_pc         = pc;
    bus.up_is_jump    = jmp;
    bus.up_taken      = tk;
    bus.up_target     = tgt;
    bus.up_pred_taken = (pred != pc + 32'd4);
    bus.up_pred_pc    = pred;
    #1;
  endtask

  task automatic idle();
    bus.lk_valid = 1'b0;
    bus.up_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.lk_valid = 1'b0; bus.lk_pc = '0;
    bus.up_valid = 1'b0; bus.up_pc = '0; bus.up_is_jump = 1'b0; bus.up_taken = 1'b0;
    bus.up_target = '0; bus.up_pred_taken = 1'b0; bus.up_pred_pc = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst.lookups", 64'(bus.stat_lookups), 64'd0);
    chk("rst.mispred", 64'(bus.stat_mispred), 64'd0);

    // 1: cold lookup
    lookup("t1", 32'h40, 1'b0, 32'h44);
    chk("t1.no_up", 64'(bus.mispredict), 64'd0);
    tick();
    idle();
    chk("t1.lookups", 64'(bus.stat_lookups), 64'd1);

    // 2: learn a taken beq
    update(32'h40, 1'b0, 1'b1, 32'h80, 32'h44);
    chk("t2.misp", 64'(bus.mispredict), 64'd1);
    chk("t2.redir", 64'(bus.redirect_pc), 64'h80);
    tick(); idle();
    chk("t2.mispred_cnt", 64'(bus.stat_mispred), 64'd1);
    lookup("t2.lk", 32'h40, 1'b1, 32'h80);
    idle();

    // 3: hysteresis (10 -> 11 -> 10 -> 01)
    update(32'h40, 1'b0, 1'b1, 32'h80, 32'h80);
    chk("t3.correct", 64'(bus.mispredict), 64'd0);
    tick(); idle();
    update(32'h40, 1'b0, 1'b0, 32'h80, 32'h80);
    chk("t3.nt1.misp", 64'(bus.mispredict), 64'd1);
    chk("t3.nt1.redir", 64'(bus.redirect_pc), 64'h44);
    tick(); idle();
    lookup("t3.still", 32'h40, 1'b1, 32'h80);
    idle();
    update(32'h40, 1'b0, 1'b0, 32'h80, 32'h80);
    tick(); idle();
    lookup("t3.flip", 32'h40, 1'b0, 32'h44);
    idle();

    // 4: aliasing on index 0
    update(32'h80, 1'b0, 1'b1, 32'h100, 32'h84);
    tick(); idle();
    lookup("t4.old", 32'h40, 1'b0, 32'h44);
    lookup("t4.new", 32'h80, 1'b1, 32'h100);
    idle();

    // 5a: same-cycle update and lookup of 0x40 sees old contents
    update(32'h40, 1'b0, 1'b1, 32'hC0, 32'h44);
    lookup("t5.same", 32'h40, 1'b0, 32'h44);
    tick(); idle();
    lookup("t5.after", 32'h40, 1'b1, 32'hC0);
    lookup("t5.evict", 32'h80, 1'b0, 32'h84);
    idle();

    // jump allocates at max: survives one not-taken
    update(32'h204, 1'b1, 1'b0, 32'h400, 32'h208);
    chk("jmp.redir", 64'(bus.redirect_pc), 64'h400);
    tick(); idle();
    update(32'h204, 1'b0, 1'b0, 32'h400, 32'h400);
    chk("jmp.nt.redir", 64'(bus.redirect_pc), 64'h208);
    tick(); idle();
    lookup("jmp.lk", 32'h204, 1'b1, 32'h400);
    idle();
    chk("mispred7", 64'(bus.stat_mispred), 64'd7);
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    idle();

    // 5b: stat saturation
    update(32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.lk_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    idle();
    chk("sat.mispred", 64'(bus.stat_mispred), 64'hF);
    chk("sat.lookups", 64'(bus.stat_lookups), 64'hF);
    lookup("sat.nochg", 32'h40, 1'b1, 32'hC0);
    idle();

    // 6: reset beats a simultaneous allocating update
    rst_n = 1'b0;
    update(32'h10, 1'b0, 1'b1, 32'h50, 32'h14);
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("t6.lookups", 64'(bus.stat_lookups), 64'd0);
    chk("t6.mispred", 64'(bus.stat_mispred), 64'd0);
    lookup("t6.alloc", 32'h10, 1'b0, 32'h14);
    lookup("t6.old", 32'h204, 1'b0, 32'h208);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
